vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Parametrised VGA/raster timing generator. Successor to the fixed 640x480 counter block.
- Adds configurable porch, sync and active widths; per-axis sync polarity; a pixel clock-enable; data-enable and blanking outputs; line and frame start strobes; a frame counter.
- Sits between the system clock and the pixel/framebuffer pipeline. Downstream blocks use its counters and strobes as the single raster time base.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels, >=1)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines, >=1)
- V_BP, 33, vertical back porch (lines)
- H_POL, 0, active level of hsync (0 = active-low)
- V_POL, 0, active level of vsync (0 = active-low)
- CNT_W, 10, counter width; must hold H_TOTAL-1 and V_TOTAL-1
- FRAME_W, 8, frame counter width

Ports:
- clk  in  1  system clock; all logic is on the rising edge
- rst  in  1  synchronous reset, active-high
- pix_en  in  1  pixel advance enable; the raster moves one pixel on each clk where pix_en=1
- haddress  out  CNT_W  current horizontal position, 0..H_TOTAL-1
- vaddress  out  CNT_W  current vertical position, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, level per H_POL
- vsync  out  1  vertical sync, level per V_POL
- de  out  1  active video; high iff haddress<H_ACTIVE and vaddress<V_ACTIVE
- hblank  out  1  high iff haddress>=H_ACTIVE
- vblank  out  1  high iff vaddress>=V_ACTIVE
- line_start  out  1  one-clk strobe on entering haddress=0
- frame_start  out  1  one-clk strobe on entering (0,0)
- frame_cnt  out  FRAME_W  completed-frame counter

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525 by default).
- All outputs are registered. Decode is computed from the next counter values, so hsync, vsync, de, hblank and vblank are aligned with haddress/vaddress in the same cycle. There is zero latency between the counters and their decode.
- Reset (rst=1 at an edge): haddress=H_TOTAL-1, vaddress=V_TOTAL-1 (last blanking pixel of the frame); hsync=!H_POL; vsync=!V_POL; de=0; hblank=1; vblank=1; line_start=0; frame_start=0; frame_cnt=0. Reset dominates pix_en. Reset mid-frame aborts the frame, and the next frame starts cleanly.
- Advance, on each edge with pix_en=1 and rst=0:
  - If haddress==H_TOTAL-1: haddress moves to 0, and vaddress moves to 0 if it equals V_TOTAL-1, otherwise it increments.
  - Otherwise haddress increments.
  - The wrap is exact: there is no extra count state at H_TOTAL or V_TOTAL.
- pix_en=0: counters and level outputs hold. line_start and frame_start are forced to 0 on that edge, so each strobe is high for exactly one clk per event regardless of the pix_en duty cycle.
- First pix_en after reset lands on (0,0), with line_start=1, frame_start=1 and de=1 (when H_ACTIVE and V_ACTIVE are >0).
- hsync is active while H_ACTIVE+H_FP <= haddress < H_ACTIVE+H_FP+H_SYNC.
- vsync is active while V_ACTIVE+V_FP <= vaddress < V_ACTIVE+V_FP+V_SYNC. vsync edges therefore coincide with haddress=0.
- line_start=1 on the edge where haddress enters 0. frame_start=1 on the edge where (haddress,vaddress) enters (0,0); line_start is also 1 on that edge.
- frame_cnt increments on the same edge frame_start asserts, except the first frame after reset, which leaves frame_cnt=0. It wraps modulo 2^FRAME_W.
- Zero-width porches (H_FP, H_BP, V_FP, V_BP = 0) are legal, and the decode ranges must remain correct.
- Parameter checks are elaboration-time assertions: H_SYNC>=1, V_SYNC>=1, H_ACTIVE>=1, V_ACTIVE>=1, and 2^CNT_W >= max(H_TOTAL, V_TOTAL). The default CNT_W=10 covers 800/525.

Test Plan:
- Defaults, pix_en=1, after reset → line_start every 800 clks; hsync low for exactly 96 clks at haddress 656..751; de high for 640 clks per visible line; frame_start every 420000 clks; de high for 307200 clks per frame.
- Defaults, vertical sync → vsync low only for vaddress 490..491 (1600 clks), with both edges coincident with haddress=0; vblank high for vaddress 480..524.
- Small config: H=4/1/2/1, V=3/1/1/1, H_POL=1, V_POL=1, pix_en=1 → line period 8 clks with hsync high at haddress 5,6; frame period 48 clks with vsync high on vaddress 4; counters wrap 7→0 and 5→0 with no state at 8 or 6.
- Small config, pix_en toggling 1,0,1,0 → all periods double; line_start and frame_start each remain exactly 1 clk wide; no counter movement on pix_en=0 cycles.
- Assert rst for 1 clk at haddress=300, vaddress=100 (defaults) → next cycle shows haddress=799, vaddress=524, de=0, syncs inactive; the first pix_en then presents (0,0) with frame_start=1 and frame_cnt=0.
- FRAME_W=2, small config, run 6 frames → frame_cnt sequence 0,1,2,3,0,1 at successive frame_start strobes.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel/line counters with registered
// sync, blanking, data-enable, line/frame strobes and a completed-frame counter.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int H_POL    = 0,
    parameter int V_POL    = 0,
    parameter int CNT_W    = 10,
    parameter int FRAME_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_en,
    output logic [CNT_W-1:0]   haddress,
    output logic [CNT_W-1:0]   vaddress,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic               hblank,
    output logic               vblank,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Sync windows use inclusive last positions so the constants always fit CNT_W.
    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT      = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT      = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_FIRST   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST    = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_LAST    = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic             HS_ON      = (H_POL != 0);
    localparam logic             VS_ON      = (V_POL != 0);

    if (H_SYNC < 1 || V_SYNC < 1 || H_ACTIVE < 1 || V_ACTIVE < 1) begin : g_bad_widths
        $error("vga_timing_gen: sync and active widths must be at least 1");
    end
    if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_cnt_w
        $error("vga_timing_gen: CNT_W too small for H_TOTAL/V_TOTAL");
    end

    logic [CNT_W-1:0] h_next;
    logic [CNT_W-1:0] v_next;
    logic             frame_seen;

    always_comb begin
        h_next = haddress + CNT_W'(1);
        v_next = vaddress;
        if (haddress == H_LAST) begin
            h_next = '0;
            v_next = (vaddress == V_LAST) ? '0 : vaddress + CNT_W'(1);
        end
    end

    // Decode from the next counter values so every level output lines up with
    // the counters it describes.
    always_ff @(posedge clk) begin
        if (rst) begin
            haddress    <= H_LAST;
            vaddress    <= V_LAST;
            hsync       <= !HS_ON;
            vsync       <= !VS_ON;
            de          <= 1'b0;
            hblank      <= 1'b1;
            vblank      <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
            frame_seen  <= 1'b0;
        end else if (pix_en) begin
            haddress    <= h_next;
            vaddress    <= v_next;
            hsync       <= (h_next >= HS_FIRST && h_next <= HS_LAST) ? HS_ON : !HS_ON;
            vsync       <= (v_next >= VS_FIRST && v_next <= VS_LAST) ? VS_ON : !VS_ON;
            de          <= (h_next < H_ACT) && (v_next < V_ACT);
            hblank      <= (h_next >= H_ACT);
            vblank      <= (v_next >= V_ACT);
            line_start  <= (h_next == '0);
            frame_start <= (h_next == '0) && (v_next == '0);
            // The frame aborted or begun by reset is not counted as completed.
            if (h_next == '0 && v_next == '0) begin
                frame_seen <= 1'b1;
                if (frame_seen) begin
                    frame_cnt <= frame_cnt + FRAME_W'(1);
                end
            end
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule
